line_mem_responder: RTL and testbench



---
 rtl/cache_pkg.sv | 25 ++
 rtl/line_mem_array.sv | 38 +++
 rtl/line_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_line_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Types and constants shared by the cache controller and its line backing store.
package cache_pkg;

  localparam int unsigned CACHE_LINE_W = 512;
  localparam int unsigned CACHE_ADDR_W = 32;
  localparam int unsigned LINE_OFS_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_LINE_W-1:0] wdata;
  } req_t;

  // The BUSY counter counts down to zero, so it starts one below the latency.
  function automatic logic [7:0] latency_load(input int unsigned lat);
    return 8'(lat - 32'd1);
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Single-port line RAM; the registered read port is also the response data register.
module line_mem_array #(
  parameter int unsigned W     = 512,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [W-1:0]     i_wdata,
  output logic [W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Registered read with a synchronous clear back to all-zero.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_rdata <= {W{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_mem_responder.sv
// Backing-store responder for cache line fills and write-backs with fixed latency.
// Optional MEM_ERR_EN: out-of-range addresses complete with rsp_err instead of wrapping.
module line_mem_responder #(
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [LINE_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  import cache_pkg::*;

  localparam int unsigned HI_LSB   = LINE_OFS_W + IDX_W;
  localparam logic [7:0]  LAT_LOAD = latency_load(LATENCY);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic              r_rsp_err;
  logic              r_busy;

  logic              w_accept;
  logic              w_fire;
  logic              w_store;
  logic              w_err;
  logic              w_mem_we;
  logic              w_mem_re;
  logic              w_mem_clr;
  logic [IDX_W-1:0]  w_req_idx;
  logic [LINE_W-1:0] w_mem_rdata;

  assign w_req_idx = req_addr[LINE_OFS_W +: IDX_W];
  assign w_accept  = req_valid && r_req_ready;
  assign w_fire    = r_rsp_valid && rsp_ready;
  assign w_store   = (r_state == BUSY) && (r_cnt == 8'd0);
  // A reset on the store edge must not commit the write or load read data.
  assign w_mem_we  = w_store && r_write && !w_err && !rst;
  assign w_mem_re  = w_store && !r_write && !w_err && !rst;
  assign w_mem_clr = rst || w_fire;

`ifdef MEM_ERR_EN
  logic r_err;
  logic w_unused;
  assign w_unused = ^req_addr[LINE_OFS_W-1:0];
  assign w_err    = r_err;

  // Out-of-range flag is sampled together with the rest of the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= |req_addr[ADDR_W-1:HI_LSB];
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{req_addr[ADDR_W-1:HI_LSB], req_addr[LINE_OFS_W-1:0]};
  assign w_err    = 1'b0;
`endif

  // Write-back line is captured once at acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wdata <= req_wdata;
    end
  end

  // Request/response sequencing with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_write     <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= BUSY;
            r_cnt       <= LAT_LOAD;
            r_write     <= req_write;
            r_idx       <= w_req_idx;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt == 8'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= r_write;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= 8'd0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_write <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  line_mem_array #(
    .W     (LINE_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_clr   (w_mem_clr),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = w_mem_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed, table-driven bench for line_mem_responder plus hand-written corner sequences.
module tb_line_mem_responder;

  localparam int LAT = 4;

`ifdef MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [511:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_write;
  logic [511:0] rsp_rdata;
  logic         rsp_err;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;
  int lat;
  logic ok;

  logic [511:0] PA, PB, PC, PD, PE, PF, P7, Z;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [511:0] wdata;
    logic [511:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  vec_t vtab [13];

  always #5 clk = ~clk;

  line_mem_responder #(
    .LINE_W  (512),
    .ADDR_W  (32),
    .IDX_W   (8),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int idx, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
  endtask

  // Present one request for exactly one accept edge; returns #1 after that edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [511:0] d, input logic rdy);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rdy;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = 32'hFFFF_FFC0;
    req_wdata = ~d;
  endtask

  // Edges counted from the accept edge (=1) until rsp_valid is seen; -1 on timeout.
  task automatic wait_valid(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) n = -1;
  endtask

  initial begin
    PA = {16{32'hDEAD_BEEF}};
    PB = {16{32'h1234_5678}};
    PC = {8{64'hA5A5_5A5A_0F0F_F0F0}};
    PD = {16{32'hCAFE_F00D}};
    PE = {64{8'h3C}};
    PF = {16{32'h0BAD_C0DE}};
    P7 = {16{32'h7777_1111}};
    Z  = 512'd0;

    vtab[0]  = '{1'b1, 32'h0000_0040, PA, Z,                 1'b0};
    vtab[1]  = '{1'b0, 32'h0000_0040, Z,  PA,                1'b0};
    vtab[2]  = '{1'b0, 32'h0000_4040, Z,  ERR_EN ? Z : PA,   ERR_EN};
    vtab[3]  = '{1'b1, 32'h0000_0080, PB, Z,                 1'b0};
    vtab[4]  = '{1'b0, 32'h0000_00A7, Z,  PB,                1'b0};
    vtab[5]  = '{1'b1, 32'h0000_3FC0, PC, Z,                 1'b0};
    vtab[6]  = '{1'b0, 32'h0000_3FFF, Z,  PC,                1'b0};
    vtab[7]  = '{1'b1, 32'h0000_0040, PD, Z,                 1'b0};
    vtab[8]  = '{1'b0, 32'h0000_0040, Z,  PD,                1'b0};
    vtab[9]  = '{1'b1, 32'h0000_0000, PE, Z,                 1'b0};
    vtab[10] = '{1'b0, 32'h0001_0000, Z,  ERR_EN ? Z : PE,   ERR_EN};
    vtab[11] = '{1'b1, 32'h0001_0040, PF, Z,                 ERR_EN};
    vtab[12] = '{1'b0, 32'h0000_0040, Z,  ERR_EN ? PD : PF,  1'b0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 512'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 0, 512'(req_ready), 512'd1);
    chk("rst_rsp_valid", 0, 512'(rsp_valid), 512'd0);
    chk("rst_busy",      0, 512'(busy),      512'd0);
    chk("rst_rsp_write", 0, 512'(rsp_write), 512'd0);
    chk("rst_rsp_err",   0, 512'(rsp_err),   512'd0);
    chk("rst_rsp_rdata", 0, rsp_rdata,       512'd0);

    for (int i = 0; i < 13; i++) begin
      send(vtab[i].wr, vtab[i].addr, vtab[i].wdata, 1'b1);
      chk("accept_busy",  i, 512'(busy),      512'd1);
      chk("accept_ready", i, 512'(req_ready), 512'd0);
      wait_valid(lat);
      chk("latency",      i, 512'(lat),       512'(LAT + 1));
      chk("rsp_write",    i, 512'(rsp_write), 512'(vtab[i].wr));
      chk("rsp_err",      i, 512'(rsp_err),   512'(vtab[i].exp_err));
      chk("rsp_rdata",    i, rsp_rdata,       vtab[i].exp_rdata);
      @(posedge clk); #1;
      chk("post_valid",   i, 512'(rsp_valid), 512'd0);
      chk("post_ready",   i, 512'(req_ready), 512'd1);
      chk("post_rdata",   i, rsp_rdata,       512'd0);
    end

    // Backpressure: response held, a waiting request is refused until after one IDLE cycle.
    send(1'b0, 32'h0000_3FC0, Z, 1'b0);
    wait_valid(lat);
    chk("bp_latency", 0, 512'(lat), 512'(LAT + 1));
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_00C0; req_wdata = P7;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== PC || req_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    chk("bp_hold_stable", 0, 512'(ok), 512'd1);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_valid", 0, 512'(rsp_valid), 512'd0);
    chk("bp_idle_ready", 0, 512'(req_ready), 512'd1);
    chk("bp_idle_busy",  0, 512'(busy),      512'd0);
    chk("bp_done_rdata", 0, rsp_rdata,       512'd0);
    @(posedge clk); #1;
    chk("bp_accept_busy",  0, 512'(busy),      512'd1);
    chk("bp_accept_ready", 0, 512'(req_ready), 512'd0);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFC0; req_wdata = Z;
    wait_valid(lat);
    chk("bp_wr_latency", 0, 512'(lat),       512'(LAT + 1));
    chk("bp_wr_write",   0, 512'(rsp_write), 512'd1);
    @(posedge clk); #1;
    send(1'b0, 32'h0000_00C0, Z, 1'b1);
    wait_valid(lat);
    chk("bp_readback", 0, rsp_rdata, P7);
    @(posedge clk); #1;

    // Reset during BUSY (s=0) and on the store edge (s=1) of a write to idx 2.
    for (int s = 0; s < 2; s++) begin
      send(1'b1, 32'h0000_0080, PD, 1'b1);
      repeat ((s == 0) ? 0 : 3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      chk("rst_mid_quiet", s, 512'(ok), 512'd1);
      send(1'b0, 32'h0000_0080, Z, 1'b1);
      wait_valid(lat);
      chk("rst_mid_latency", s, 512'(lat), 512'(LAT + 1));
      chk("rst_mid_keep",    s, rsp_rdata, PB);
      @(posedge clk); #1;
    end

    // Reset while a read response is waiting.
    send(1'b0, 32'h0000_0080, Z, 1'b0);
    wait_valid(lat);
    chk("resp_rst_pre", 0, rsp_rdata, PB);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("resp_rst_valid", 0, 512'(rsp_valid), 512'd0);
    chk("resp_rst_rdata", 0, rsp_rdata,       512'd0);
    chk("resp_rst_ready", 0, 512'(req_ready), 512'd1);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) ok = 1'b0;
    end
    chk("resp_rst_quiet", 0, 512'(ok), 512'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
